// File: rtl/mips_rf_pkg.sv
// Shared MIPS register-file constants and address legality helper.
// Only registers 0 and REG_LO..REG_HI physically exist.
package mips_rf_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned REG_LO = 8;
    localparam int unsigned REG_HI = 25;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [ADDR_W-1:0] REG_T0   = 5'd8;
    localparam logic [ADDR_W-1:0] REG_T1   = 5'd9;
    localparam logic [ADDR_W-1:0] REG_T2   = 5'd10;
    localparam logic [ADDR_W-1:0] REG_T3   = 5'd11;
    localparam logic [ADDR_W-1:0] REG_T4   = 5'd12;
    localparam logic [ADDR_W-1:0] REG_T5   = 5'd13;
    localparam logic [ADDR_W-1:0] REG_T6   = 5'd14;
    localparam logic [ADDR_W-1:0] REG_T7   = 5'd15;
    localparam logic [ADDR_W-1:0] REG_S0   = 5'd16;
    localparam logic [ADDR_W-1:0] REG_S1   = 5'd17;
    localparam logic [ADDR_W-1:0] REG_S2   = 5'd18;
    localparam logic [ADDR_W-1:0] REG_S3   = 5'd19;
    localparam logic [ADDR_W-1:0] REG_S4   = 5'd20;
    localparam logic [ADDR_W-1:0] REG_S5   = 5'd21;
    localparam logic [ADDR_W-1:0] REG_S6   = 5'd22;
    localparam logic [ADDR_W-1:0] REG_S7   = 5'd23;
    localparam logic [ADDR_W-1:0] REG_T8   = 5'd24;
    localparam logic [ADDR_W-1:0] REG_T9   = 5'd25;

    // Register 0 is never legal to write, so the range check alone covers it.
    function automatic logic rf_addr_legal(
        logic [ADDR_W-1:0] addr,
        logic [ADDR_W-1:0] lo = REG_T0,
        logic [ADDR_W-1:0] hi = REG_T9
    );
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester not granted last time wins.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = last_q ? 2'b01 : 2'b10;
        end
        last_d = last_q;
        if (gnt_o != 2'b00) begin
            last_d = gnt_o[1];
        end
    end

    // Reset to requester 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Register-file write-port scheduler: arbitrates ALU/MEM writebacks onto the single
// write port and keeps a pending-write scoreboard for RAW/WAW detection at decode.
module rf_wb_scheduler
    import mips_rf_pkg::*;
#(
    parameter int unsigned DATA_W     = mips_rf_pkg::DATA_W,
    parameter int unsigned ADDR_W     = mips_rf_pkg::ADDR_W,
    parameter int unsigned REG_LO     = mips_rf_pkg::REG_LO,
    parameter int unsigned REG_HI     = mips_rf_pkg::REG_HI,
    parameter int unsigned DROP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  r0_valid_i,
    input  logic [ADDR_W-1:0]     r0_addr_i,
    input  logic [DATA_W-1:0]     r0_data_i,
    output logic                  r0_ready_o,
    input  logic                  r1_valid_i,
    input  logic [ADDR_W-1:0]     r1_addr_i,
    input  logic [DATA_W-1:0]     r1_data_i,
    output logic                  r1_ready_o,
    input  logic                  issue_valid_i,
    input  logic [ADDR_W-1:0]     issue_dst_i,
    output logic                  issue_ready_o,
    input  logic [ADDR_W-1:0]     src1_i,
    input  logic [ADDR_W-1:0]     src2_i,
    output logic                  stall_o,
    input  logic                  flush_i,
    output logic                  reg_write_en_o,
    output logic [ADDR_W-1:0]     write_address_o,
    output logic [DATA_W-1:0]     write_data_o,
    output logic [31:0]           busy_o,
    output logic [DROP_CNT_W-1:0] drop_cnt_o
);

    localparam logic [ADDR_W-1:0] Lo = ADDR_W'(REG_LO);
    localparam logic [ADDR_W-1:0] Hi = ADDR_W'(REG_HI);

    logic [1:0]            gnt;
    logic                  any_gnt;
    logic [ADDR_W-1:0]     sel_addr;
    logic [DATA_W-1:0]     sel_data;
    logic                  sel_legal;
    logic                  legal_gnt;
    logic                  dst_legal;
    logic [31:0]           clr_vec;
    logic [31:0]           set_vec;

    logic                  we_q, we_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic [31:0]           busy_q, busy_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i ({r1_valid_i, r0_valid_i}),
        .gnt_o (gnt)
    );

    assign r0_ready_o = gnt[0];
    assign r1_ready_o = gnt[1];
    assign any_gnt    = |gnt;
    assign sel_addr   = gnt[1] ? r1_addr_i : r0_addr_i;
    assign sel_data   = gnt[1] ? r1_data_i : r0_data_i;
    assign sel_legal  = rf_addr_legal(sel_addr, Lo, Hi);
    assign legal_gnt  = any_gnt & sel_legal;
    assign dst_legal  = rf_addr_legal(issue_dst_i, Lo, Hi);

    // A same-cycle legal write to the destination frees it, so no WAW.
    assign issue_ready_o = ~busy_q[issue_dst_i]
                         | (legal_gnt && (sel_addr == issue_dst_i))
                         | (issue_dst_i == '0);

    assign stall_o = ((src1_i != '0) & busy_q[src1_i]) | ((src2_i != '0) & busy_q[src2_i]);

    always_comb begin
        clr_vec = '0;
        set_vec = '0;
        if (legal_gnt) begin
            clr_vec = 32'd1 << sel_addr;
        end
        if (issue_valid_i && issue_ready_o && dst_legal) begin
            set_vec = 32'd1 << issue_dst_i;
        end
        // Set is applied after clear so it wins on the same register.
        busy_d = flush_i ? set_vec : ((busy_q & ~clr_vec) | set_vec);

        we_d   = legal_gnt;
        addr_d = addr_q;
        data_d = data_q;
        if (any_gnt) begin
            addr_d = sel_addr;
            data_d = sel_data;
        end

        drop_d = drop_q;
        if (any_gnt && !sel_legal && (drop_q != {DROP_CNT_W{1'b1}})) begin
            drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            busy_q <= '0;
            drop_q <= '0;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
            busy_q <= busy_d;
            drop_q <= drop_d;
        end
    end

    assign reg_write_en_o  = we_q;
    assign write_address_o = addr_q;
    assign write_data_o    = data_q;
    assign busy_o          = busy_q;
    assign drop_cnt_o      = drop_q;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed self-checking bench for rf_wb_scheduler.
module tb_rf_wb_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0_valid, r1_valid, issue_valid, flush;
    logic [4:0]  r0_addr, r1_addr, issue_dst, src1, src2;
    logic [31:0] r0_data, r1_data;
    logic        r0_ready, r1_ready, issue_ready, stall;
    logic        reg_write_en;
    logic [4:0]  write_address;
    logic [31:0] write_data;
    logic [31:0] busy;
    logic [7:0]  drop_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rf_wb_scheduler dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .r0_valid_i      (r0_valid),
        .r0_addr_i       (r0_addr),
        .r0_data_i       (r0_data),
        .r0_ready_o      (r0_ready),
        .r1_valid_i      (r1_valid),
        .r1_addr_i       (r1_addr),
        .r1_data_i       (r1_data),
        .r1_ready_o      (r1_ready),
        .issue_valid_i   (issue_valid),
        .issue_dst_i     (issue_dst),
        .issue_ready_o   (issue_ready),
        .src1_i          (src1),
        .src2_i          (src2),
        .stall_o         (stall),
        .flush_i         (flush),
        .reg_write_en_o  (reg_write_en),
        .write_address_o (write_address),
        .write_data_o    (write_data),
        .busy_o          (busy),
        .drop_cnt_o      (drop_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        r0_valid = 0; r0_addr = 0; r0_data = 0;
        r1_valid = 0; r1_addr = 0; r1_data = 0;
        issue_valid = 0; issue_dst = 0; src1 = 0; src2 = 0; flush = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        r0_valid = 1; r0_addr = 5'd3; r0_data = 32'h1;
        tick();
        r0_addr = 5'd8; r0_data = 32'h5; issue_valid = 1; issue_dst = 5'd10;
        tick();
        r0_valid = 0; issue_valid = 0;
        checks++; if (reg_write_en !== 1'b1) begin failures++; $display("FAIL pre_reset_we: got %0h expected 1", reg_write_en); end
        checks++; if (drop_cnt !== 8'd1) begin failures++; $display("FAIL pre_reset_drop: got %0d expected 1", drop_cnt); end
        #2; rst_n = 0; #1;
        checks++; if (reg_write_en !== 1'b0) begin failures++; $display("FAIL reset_we: got %0h expected 0", reg_write_en); end
        checks++; if (write_address !== 5'd0) begin failures++; $display("FAIL reset_addr: got %0h expected 0", write_address); end
        checks++; if (write_data !== 32'd0) begin failures++; $display("FAIL reset_data: got %0h expected 0", write_data); end
        checks++; if (busy !== 32'd0) begin failures++; $display("FAIL reset_busy: got %0h expected 0", busy); end
        checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
        @(negedge clk);
        r0_valid = 1; r0_addr = 5'd8; r0_data = 32'h11;
        r1_valid = 1; r1_addr = 5'd9; r1_data = 32'h22;
        rst_n = 1; #1;
        checks++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin failures++; $display("FAIL reset_first_tie: got r0=%0h r1=%0h expected r0=1 r1=0", r0_ready, r1_ready); end
        tick();
        r0_valid = 0; r1_valid = 0;
        checks++; if (write_address !== 5'd8 || write_data !== 32'h11) begin failures++; $display("FAIL reset_first_commit: got %0h/%0h expected 8/11", write_address, write_data); end
    endtask

    task automatic test_contention();
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        do_reset();
        r0_valid = 1; r0_addr = 5'd8; r0_data = 32'hA;
        r1_valid = 1; r1_addr = 5'd9; r1_data = 32'hB;
        for (int i = 0; i < 3; i++) begin
            #4;
            checks++; if (r0_ready !== (i % 2 == 0) || r1_ready !== (i % 2 == 1)) begin failures++; $display("FAIL contention_grant[%0d]: got r0=%0h r1=%0h", i, r0_ready, r1_ready); end
            exp_addr = (i % 2 == 1) ? 5'd9 : 5'd8;
            exp_data = (i % 2 == 1) ? 32'hB : 32'hA;
            tick();
            checks++; if (reg_write_en !== 1'b1 || write_address !== exp_addr || write_data !== exp_data) begin failures++; $display("FAIL contention_commit[%0d]: got en=%0h %0h/%0h expected 1 %0h/%0h", i, reg_write_en, write_address, write_data, exp_addr, exp_data); end
        end
        r0_valid = 0; r1_valid = 0;
        tick();
        checks++; if (reg_write_en !== 1'b0) begin failures++; $display("FAIL contention_idle_we: got %0h expected 0", reg_write_en); end
    endtask

    task automatic test_scoreboard();
        issue_valid = 1; issue_dst = 5'd16;
        #4;
        checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL sb_issue_ready: got %0h expected 1", issue_ready); end
        tick();
        issue_valid = 0;
        checks++; if (busy[16] !== 1'b1) begin failures++; $display("FAIL sb_busy_set: got %0h expected 1", busy[16]); end
        src1 = 5'd16; #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL sb_stall: got %0h expected 1", stall); end
        r1_valid = 1; r1_addr = 5'd16; r1_data = 32'h1234; #1;
        checks++; if (r1_ready !== 1'b1 || stall !== 1'b1) begin failures++; $display("FAIL sb_grant_no_bypass: got ready=%0h stall=%0h expected 1 1", r1_ready, stall); end
        tick();
        r1_valid = 0;
        checks++; if (busy[16] !== 1'b0) begin failures++; $display("FAIL sb_busy_clear: got %0h expected 0", busy[16]); end
        checks++; if (reg_write_en !== 1'b1 || write_address !== 5'd16 || write_data !== 32'h1234) begin failures++; $display("FAIL sb_commit: got en=%0h %0h/%0h expected 1 10/1234", reg_write_en, write_address, write_data); end
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL sb_stall_drop: got %0h expected 0", stall); end
        src1 = 0;
    endtask

    task automatic test_waw();
        issue_valid = 1; issue_dst = 5'd17;
        tick();
        #1;
        checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL waw_block: got %0h expected 0", issue_ready); end
        r0_valid = 1; r0_addr = 5'd17; r0_data = 32'h7; #1;
        checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL waw_grant_ready: got %0h expected 1", issue_ready); end
        tick();
        r0_valid = 0; issue_valid = 0;
        checks++; if (busy[17] !== 1'b1) begin failures++; $display("FAIL waw_set_wins: got %0h expected 1", busy[17]); end
        r0_valid = 1;
        tick();
        r0_valid = 0;
        checks++; if (busy[17] !== 1'b0) begin failures++; $display("FAIL waw_final_clear: got %0h expected 0", busy[17]); end
    endtask

    task automatic test_illegal();
        do_reset();
        r0_valid = 1; r0_addr = 5'd0; r0_data = 32'hDEAD; #1;
        checks++; if (r0_ready !== 1'b1) begin failures++; $display("FAIL illegal0_ready: got %0h expected 1", r0_ready); end
        tick();
        checks++; if (reg_write_en !== 1'b0 || drop_cnt !== 8'd1) begin failures++; $display("FAIL illegal0_commit: got en=%0h drop=%0d expected 0 1", reg_write_en, drop_cnt); end
        r0_addr = 5'd30; #1;
        checks++; if (r0_ready !== 1'b1) begin failures++; $display("FAIL illegal30_ready: got %0h expected 1", r0_ready); end
        tick();
        r0_valid = 0;
        checks++; if (reg_write_en !== 1'b0 || drop_cnt !== 8'd2) begin failures++; $display("FAIL illegal30_commit: got en=%0h drop=%0d expected 0 2", reg_write_en, drop_cnt); end
        issue_valid = 1; issue_dst = 5'd30; #1;
        checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL illegal_issue_ready: got %0h expected 1", issue_ready); end
        tick();
        issue_valid = 0;
        checks++; if (busy !== 32'd0) begin failures++; $display("FAIL illegal_issue_nobit: got %0h expected 0", busy); end
        r0_valid = 1; r0_addr = 5'd31;
        repeat (252) tick();
        checks++; if (drop_cnt !== 8'd254) begin failures++; $display("FAIL drop_count_254: got %0d expected 254", drop_cnt); end
        repeat (48) tick();
        r0_valid = 0;
        checks++; if (drop_cnt !== 8'd255) begin failures++; $display("FAIL drop_saturate: got %0d expected 255", drop_cnt); end
    endtask

    task automatic test_flush();
        logic [4:0] dsts [3];
        dsts[0] = 5'd8; dsts[1] = 5'd9; dsts[2] = 5'd20;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            issue_valid = 1; issue_dst = dsts[i];
            tick();
        end
        issue_valid = 0;
        checks++; if (busy !== 32'h0010_0300) begin failures++; $display("FAIL flush_pre_busy: got %0h expected 100300", busy); end
        src2 = 5'd20; #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL flush_src2_stall: got %0h expected 1", stall); end
        src2 = 0;
        flush = 1; issue_valid = 1; issue_dst = 5'd21;
        r1_valid = 1; r1_addr = 5'd9; r1_data = 32'h99; #1;
        checks++; if (r1_ready !== 1'b1 || issue_ready !== 1'b1) begin failures++; $display("FAIL flush_same_cycle: got ready=%0h issue_ready=%0h expected 1 1", r1_ready, issue_ready); end
        tick();
        flush = 0; issue_valid = 0; r1_valid = 0;
        checks++; if (busy !== 32'h0020_0000) begin failures++; $display("FAIL flush_busy: got %0h expected 200000", busy); end
        checks++; if (reg_write_en !== 1'b1 || write_address !== 5'd9 || write_data !== 32'h99) begin failures++; $display("FAIL flush_commit: got en=%0h %0h/%0h expected 1 9/99", reg_write_en, write_address, write_data); end
    endtask

    initial begin
        rst_n = 0;
        clear_inputs();
        test_reset();
        test_contention();
        test_scoreboard();
        test_waw();
        test_illegal();
        test_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
